bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr_pkg.sv | 19 +
 rtl/bus_arbiter_rr_if.sv | 28 ++
 rtl/rr_priority_select.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 105 ++++++++++
 tb/tb_bus_arbiter_rr.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// rtl/bus_arbiter_rr_pkg.sv - shared state encoding and width helper for the bus blocks
package bus_arbiter_rr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Bits needed to index `value` items; never less than one so 1-port builds stay legal.
  function automatic int arb_log2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// rtl/bus_arbiter_rr_if.sv - request/grant bundle between requesters, arbiter and bus mux
interface bus_arbiter_rr_if #(
  parameter int NUM_PORTS = 4
);
  import bus_arbiter_rr_pkg::*;

  localparam int PW = arb_log2(NUM_PORTS);

  logic [NUM_PORTS-1:0] requests;
  logic [PW-1:0]        grant_port;
  logic                 grant_valid;
  logic [NUM_PORTS-1:0] grant_onehot;

  modport master (
    input  requests,
    output grant_port,
    output grant_valid,
    output grant_onehot
  );

  modport slave (
    output requests,
    input  grant_port,
    input  grant_valid,
    input  grant_onehot
  );

endinterface

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - circular first-requester search starting just after last_port
module rr_priority_select
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PW        = arb_log2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] requests,
  input  logic [PW-1:0]        last_port,
  output logic [PW-1:0]        next_port,
  output logic                 any_req
);

  logic [PW-1:0] cand;

  // last_port itself is visited last, so it only wins when it is the sole requester.
  always_comb begin
    next_port = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(last_port) + i) % NUM_PORTS);
      if (!any_req && requests[cand]) begin
        next_port = cand;
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with bounded hold time and registered grants
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8
) (
  input  logic             clock,
  input  logic             reset,
  bus_arbiter_rr_if.master arb
);

  localparam int            PW         = arb_log2(NUM_PORTS);
  localparam int            HW         = arb_log2(MAX_HOLD);
  localparam logic [PW-1:0] LAST_INIT  = PW'(NUM_PORTS - 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD - 1);

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        port_q, port_d;
  logic [NUM_PORTS-1:0] onehot_q, onehot_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [PW-1:0]        last_q, last_d;

  logic [NUM_PORTS-1:0] sel_req;
  logic [PW-1:0]        next_port;
  logic                 any_req;
  logic                 owner_req;
  logic                 take;
  logic                 drop;

  // Masking the owner keeps it out of every handover; onehot_q is zero in IDLE.
  assign sel_req   = arb.requests & ~onehot_q;
  assign owner_req = |(arb.requests & onehot_q);

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_select (
    .requests  (sel_req),
    .last_port (last_q),
    .next_port (next_port),
    .any_req   (any_req)
  );

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    onehot_d = onehot_q;
    hold_d   = hold_q;
    last_d   = last_q;
    take     = 1'b0;
    drop     = 1'b0;

    case (state_q)
      ST_IDLE: take = any_req;
      ST_GRANT: begin
        if (!owner_req) begin
          take = any_req;
          drop = !any_req;
        end else if (hold_q != HOLD_LIMIT) begin
          hold_d = hold_q + 1'b1;
        end else if (any_req) begin
          take = 1'b1;
        end else begin
          hold_d = '0;
        end
      end
      default: drop = 1'b1;
    endcase

    if (take) begin
      state_d  = ST_GRANT;
      port_d   = next_port;
      onehot_d = NUM_PORTS'(1) << next_port;
      hold_d   = '0;
      last_d   = next_port;
    end else if (drop) begin
      state_d  = ST_IDLE;
      port_d   = '0;
      onehot_d = '0;
      hold_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      port_q   <= '0;
      onehot_q <= '0;
      hold_q   <= '0;
      last_q   <= LAST_INIT;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      onehot_q <= onehot_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
    end
  end

  assign arb.grant_valid  = (state_q == ST_GRANT);
  assign arb.grant_port   = port_q;
  assign arb.grant_onehot = onehot_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed and randomized checks of bus_arbiter_rr against a behavioural model
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int MH = 8;

  logic        clock;
  logic        reset;
  logic        chk_en;
  logic [31:0] data_in;
  int          tests;
  int          fails;

  int m_owner;
  int m_hold;
  int m_last;

  bus_arbiter_rr_if #(.NUM_PORTS(N)) bus ();

  bus_arbiter_rr #(
    .NUM_PORTS (N),
    .MAX_HOLD  (MH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .arb   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Reference: who owns the bus after this edge, from the arbitration rules alone.
  always @(posedge clock) begin
    logic [N-1:0] r;
    logic [N-1:0] others;
    r = bus.requests;
    if (reset) begin
      m_owner = -1;
      m_hold  = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = rr_pick(r, m_last);
        m_hold  = 0;
        m_last  = m_owner;
      end
    end else begin
      others = r & ~(N'(1) << m_owner);
      if (!r[m_owner]) begin
        if (others != 0) begin
          m_owner = rr_pick(others, m_last);
          m_hold  = 0;
          m_last  = m_owner;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end else if (m_hold < MH - 1) begin
        m_hold = m_hold + 1;
      end else if (others != 0) begin
        m_owner = rr_pick(others, m_last);
        m_hold  = 0;
        m_last  = m_owner;
      end else begin
        m_hold = 0;
      end
    end
  end

  always @(negedge clock) begin
    logic [N-1:0] exp_oh;
    if (chk_en) begin
      exp_oh = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      tests++;
      if (bus.grant_valid !== (m_owner >= 0)) begin
        fails++;
        $display("FAIL model_valid t=%0t got=%b exp=%b", $time, bus.grant_valid, (m_owner >= 0));
      end
      tests++;
      if (int'(bus.grant_port) != ((m_owner >= 0) ? m_owner : 0) || $isunknown(bus.grant_port)) begin
        fails++;
        $display("FAIL model_port t=%0t got=%0d exp=%0d", $time, bus.grant_port, (m_owner >= 0) ? m_owner : 0);
      end
      tests++;
      if (bus.grant_onehot !== exp_oh) begin
        fails++;
        $display("FAIL model_onehot t=%0t got=%b exp=%b", $time, bus.grant_onehot, exp_oh);
      end
    end
  end

  task automatic cyc(input logic [N-1:0] r);
    bus.requests = r;
    @(posedge clock);
    #2;
  endtask

  task automatic check_lit(input string name, input logic ev, input int ep);
    logic [N-1:0] eoh;
    eoh = ev ? (N'(1) << ep) : '0;
    tests++;
    if (bus.grant_valid !== ev || int'(bus.grant_port) != ep || bus.grant_onehot !== eoh) begin
      fails++;
      $display("FAIL %s dut got valid=%b port=%0d onehot=%b exp valid=%b port=%0d onehot=%b",
               name, bus.grant_valid, bus.grant_port, bus.grant_onehot, ev, ep, eoh);
    end
    tests++;
    if ((m_owner >= 0) !== ev || (ev && m_owner != ep)) begin
      fails++;
      $display("FAIL %s model got owner=%0d exp valid=%b port=%0d", name, m_owner, ev, ep);
    end
  endtask

  task automatic check_mux(input string name, input logic [7:0] exp);
    logic [7:0] b;
    b = bus.grant_valid ? data_in[8*bus.grant_port +: 8] : 8'h00;
    tests++;
    if (b !== exp) begin
      fails++;
      $display("FAIL %s data_out got=%h exp=%h", name, b, exp);
    end
  endtask

  initial begin
    logic [N-1:0] r;
    tests        = 0;
    fails        = 0;
    chk_en       = 1'b0;
    data_in      = 32'h89ABCDEF;
    m_owner      = -1;
    m_hold       = 0;
    m_last       = N - 1;
    reset        = 1'b1;
    bus.requests = 4'b1111;
    @(posedge clock);
    #2;
    chk_en = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111);
      check_lit("reset_hold", 1'b0, 0);
    end
    reset = 1'b0;
    cyc(4'b1111);
    check_lit("first_after_reset", 1'b1, 0);

    for (int p = 0; p < N; p++) begin
      cyc(4'b1111);
      check_lit("rr_hold", 1'b1, p);
      cyc(4'b1111 & ~(4'b0001 << p));
      check_lit("rr_handover", 1'b1, (p + 1) % N);
    end

    cyc(4'b0000);
    check_lit("release_idle", 1'b0, 0);
    cyc(4'b0000);
    check_lit("stay_idle", 1'b0, 0);
    cyc(4'b0100);
    check_lit("regrant", 1'b1, 2);

    for (int i = 0; i < MH - 1; i++) begin
      cyc(4'b0110);
      check_lit("maxhold_keep", 1'b1, 2);
    end
    cyc(4'b0110);
    check_lit("maxhold_to_p1", 1'b1, 1);

    cyc(4'b0000);
    cyc(4'b0100);
    check_lit("grant_p2_again", 1'b1, 2);
    for (int i = 0; i < MH - 1; i++) cyc(4'b1110);
    check_lit("maxhold_last_keep", 1'b1, 2);
    cyc(4'b1110);
    check_lit("maxhold_to_p3", 1'b1, 3);

    cyc(4'b0000);
    cyc(4'b1000);
    check_lit("sole_grant", 1'b1, 3);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1000);
      check_lit("sole_hold", 1'b1, 3);
    end

    cyc(4'b0000);
    check_mux("mux_idle_a", 8'h00);
    cyc(4'b0010);
    check_mux("mux_p1", 8'hCD);
    cyc(4'b0100);
    check_mux("mux_p2", 8'hAB);
    cyc(4'b1000);
    check_mux("mux_p3", 8'h89);
    cyc(4'b0001);
    check_mux("mux_p0", 8'hEF);
    cyc(4'b0000);
    check_mux("mux_idle_b", 8'h00);

    cyc(4'b0001);
    check_lit("pre_reset_grant", 1'b1, 0);
    reset = 1'b1;
    cyc(4'b0001);
    check_lit("reset_drops_grant", 1'b0, 0);
    reset = 1'b0;
    cyc(4'b1111);
    check_lit("post_reset_p0", 1'b1, 0);

    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      reset = ($urandom_range(0, 199) == 0);
      cyc(r);
    end
    reset = 1'b0;
    cyc(4'b0000);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
